// File: rtl/udp_stream_tx.sv
`default_nettype none
// ============================================================================
// Module  : udp_stream_tx
// Packs a FIFO-buffered 32-bit word stream into datagrams on the GEMAC SEND_* port.
// Option  : define UDP_STREAM_TX_SEQNUM_EN to prepend a 32-bit sequence word.
// Rev     : 1.0  initial release
// ============================================================================
module udp_stream_tx #(
  parameter int          FIFO_AW      = 9,
  parameter int          MAX_WORDS    = 256,
  parameter int          FLUSH_CYCLES = 100000,
  parameter logic [15:0] DST_PORT     = 16'd1234,
  parameter logic [15:0] SRC_PORT     = 16'd1234
) (
  input  logic        RST_N,
  input  logic        CLK100MHZ,
  input  logic        ARPC_VALID,
  input  logic        IN_VALID,
  input  logic [31:0] IN_DATA,
  output logic        IN_READY,
  output logic        SEND_REQUEST,
  output logic [15:0] SEND_LENGTH,
  input  logic        SEND_BUSY,
  output logic [15:0] SEND_DSTPORT,
  output logic [15:0] SEND_SRCPORT,
  output logic        SEND_DATA_VALID,
  input  logic        SEND_DATA_READ,
  output logic [31:0] SEND_DATA,
  output logic [15:0] PKT_COUNT,
  output logic [15:0] DROP_COUNT
);

  localparam int                c_DEPTH = 1 << FIFO_AW;
  localparam int                c_TW    = $clog2(FLUSH_CYCLES + 1);
  localparam logic [c_TW-1:0]   c_FLUSH = c_TW'(FLUSH_CYCLES);
  localparam logic [FIFO_AW:0]  c_MAXW  = (FIFO_AW+1)'(MAX_WORDS);
  localparam logic [FIFO_AW:0]  c_FULL  = (FIFO_AW+1)'(c_DEPTH);
  localparam logic [FIFO_AW:0]  c_ONE   = (FIFO_AW+1)'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         r_state, w_next;
  logic [31:0]        r_mem [c_DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [FIFO_AW:0]   r_count, r_remaining, w_nwords;
  logic [c_TW-1:0]    r_timer;
  logic               r_ready_en;
  logic [15:0]        r_len, r_pkt, r_drop, w_len;
  logic [31:0]        w_head;
  logic               w_full, w_push, w_pop, w_launch, w_req, w_valid, w_seq_phase, w_done_ok;

  assign w_full    = (r_count == c_FULL);
  assign IN_READY  = r_ready_en & ~w_full;
  assign w_push    = IN_VALID & IN_READY;
  assign w_pop     = w_valid & SEND_DATA_READ & ~w_seq_phase;
  assign w_nwords  = (r_count >= c_MAXW) ? c_MAXW : r_count;
  assign w_launch  = (r_state == S_IDLE) & ARPC_VALID &
                     ((r_count >= c_MAXW) | ((r_count != '0) & (r_timer == c_FLUSH)));
  assign w_done_ok = (r_state == S_DONE) & ~SEND_BUSY;

  always_ff @(posedge CLK100MHZ or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_launch) w_next = S_REQ;
      S_REQ:   if (SEND_BUSY) w_next = S_DATA;
      S_DATA:  if (w_pop && (r_remaining == c_ONE)) w_next = S_DONE;
      S_DONE:  if (!SEND_BUSY) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_req   = (r_state == S_REQ);
    w_valid = (r_state == S_DATA);
  end

  // Storage carries no reset: contents are only observable through valid pointers.
  always_ff @(posedge CLK100MHZ) begin
    if (w_push) r_mem[r_wr_ptr] <= IN_DATA;
  end

  always_ff @(posedge CLK100MHZ or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_ONE;
        2'b01:   r_count <= r_count - c_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ or negedge RST_N) begin
    if (!RST_N)
      r_timer <= '0;
    else if ((r_state != S_IDLE) || (r_count == '0) || w_push || w_launch)
      r_timer <= '0;
    else if (r_timer != c_FLUSH)
      r_timer <= r_timer + 1'b1;
  end

  always_ff @(posedge CLK100MHZ or negedge RST_N) begin
    if (!RST_N) begin
      r_remaining <= '0;
      r_len       <= '0;
      r_pkt       <= '0;
      r_drop      <= '0;
    end else begin
      if (w_launch) begin
        r_remaining <= w_nwords;
        r_len       <= w_len;
      end else if (w_pop) begin
        r_remaining <= r_remaining - c_ONE;
      end
      if (w_done_ok) r_pkt <= r_pkt + 1'b1;
      if (IN_VALID && w_full && (r_drop != 16'hFFFF)) r_drop <= r_drop + 1'b1;
    end
  end

`ifdef UDP_STREAM_TX_SEQNUM_EN
  logic        r_seq_phase;
  logic [31:0] r_seq;

  // The sequence word occupies the first DATA beat and never pops the FIFO.
  always_ff @(posedge CLK100MHZ or negedge RST_N) begin
    if (!RST_N) begin
      r_seq_phase <= 1'b0;
      r_seq       <= '0;
    end else begin
      if ((r_state == S_REQ) && SEND_BUSY) r_seq_phase <= 1'b1;
      else if (w_valid && SEND_DATA_READ)  r_seq_phase <= 1'b0;
      if (w_done_ok) r_seq <= r_seq + 1'b1;
    end
  end

  assign w_seq_phase = r_seq_phase;
  assign w_head      = r_seq_phase ? r_seq : r_mem[r_rd_ptr];
  assign w_len       = 16'(w_nwords + c_ONE) << 2;
`else
  assign w_seq_phase = 1'b0;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_len       = 16'(w_nwords) << 2;
`endif

  assign SEND_REQUEST    = w_req;
  assign SEND_DATA_VALID = w_valid;
  assign SEND_DATA       = w_valid ? w_head : 32'd0;
  assign SEND_LENGTH     = r_len;
  assign SEND_DSTPORT    = DST_PORT;
  assign SEND_SRCPORT    = SRC_PORT;
  assign PKT_COUNT       = r_pkt;
  assign DROP_COUNT      = r_drop;

endmodule
`default_nettype wire
